// File: rtl/fact_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fact_seq_ctrl
//
// Sequencing controller for the factorial ALU datapath. On a start request it
// reads operand N from data memory, steps the ALU (counter/memreg) until the
// counter reaches 1, writes N! back to memory and pulses done.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; src/dst captured on the accepting edge
//   READ  | memory read of operand at src
//   LOAD  | ALU counter <= memout, memreg <= 1; N and overflow captured
//   ITER  | one multiply step per cycle while counter_out > 1
//   WRITE | result written to dst (1 when N == 0)
//   DONE  | one-cycle done pulse, overflow valid
//
// Ports:
//   clock, reset_n          system clock (rising edge), async active-low reset
//   start                   operation request, honoured in IDLE only
//   src_addr, dst_addr      operand / result addresses
//   busy, done, overflow    status (overflow qualified by done)
//   mem_addr, mem_rd,
//   mem_wr, mem_wdata       data memory interface
//   memout                  memory read data (valid the cycle after mem_rd)
//   memreg_set/_reset,
//   counter_set/_reset      ALU control strobes
//   counter_out, res        ALU counter value and counter*memreg product
// -----------------------------------------------------------------------------
module fact_seq_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int RES_W  = 16,
  parameter int MAX_N  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [RES_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0] memout,
  output logic              memreg_set,
  output logic              memreg_reset,
  output logic              counter_set,
  output logic              counter_reset,
  input  logic [DATA_W-1:0] counter_out,
  input  logic [RES_W-1:0]  res
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    ITER  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [DATA_W-1:0] MaxN    = DATA_W'(MAX_N);
  localparam logic [DATA_W-1:0] CntOne  = DATA_W'(1);
  localparam logic [RES_W-1:0]  ResOne  = RES_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] n_q;
  logic              ovf_q;
  logic              iter_more;

  // Another multiply step is needed while the ALU counter is above 1.
  assign iter_more = (counter_out > CntOne);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Operation context: addresses on acceptance, operand and overflow at LOAD
  // (memout carries the operand during LOAD, one cycle after the READ strobe).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= '0;
      dst_q <= '0;
      n_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
      end
      if (state == LOAD) begin
        n_q   <= memout;
        ovf_q <= (memout > MaxN);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? READ : IDLE;
      READ:    state_nxt = LOAD;
      LOAD:    state_nxt = ITER;
      ITER:    state_nxt = iter_more ? ITER : WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Only the ITER set strobes look at counter_out; set and reset
  // strobes live in different states, so they can never coincide (the ALU
  // would otherwise let set win).
  // ---------------------------------------------------------------------------
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    overflow      = 1'b0;
    mem_addr      = '0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    mem_wdata     = '0;
    memreg_set    = 1'b0;
    memreg_reset  = 1'b0;
    counter_set   = 1'b0;
    counter_reset = 1'b0;
    case (state)
      READ: begin
        busy     = 1'b1;
        mem_addr = src_q;
        mem_rd   = 1'b1;
      end
      LOAD: begin
        busy          = 1'b1;
        memreg_reset  = 1'b1;
        counter_reset = 1'b1;
      end
      ITER: begin
        busy        = 1'b1;
        memreg_set  = iter_more;
        counter_set = iter_more;
      end
      WRITE: begin
        busy     = 1'b1;
        mem_addr = dst_q;
        mem_wr   = 1'b1;
        // With N == 0 the counter holds 0 and the ALU product is 0, but 0! = 1.
        mem_wdata = (n_q == '0) ? ResOne : res;
      end
      DONE: begin
        done     = 1'b1;
        overflow = ovf_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fact_seq_ctrl.sv
module tb_fact_seq_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int RES_W  = 16;
  localparam int MAX_N  = 5;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic              busy, done, overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, mem_wr;
  logic [RES_W-1:0]  mem_wdata;
  logic [DATA_W-1:0] memout = '0;
  logic              memreg_set, memreg_reset, counter_set, counter_reset;
  logic [DATA_W-1:0] counter_out;
  logic [RES_W-1:0]  res;

  fact_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W), .MAX_N(MAX_N)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr),
    .busy(busy), .done(done), .overflow(overflow),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .memout(memout),
    .memreg_set(memreg_set), .memreg_reset(memreg_reset),
    .counter_set(counter_set), .counter_reset(counter_reset),
    .counter_out(counter_out), .res(res)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Data memory: read data appears the cycle after the read strobe.
  logic [DATA_W-1:0] mem [16];
  always @(posedge clock) if (mem_rd) memout <= mem[mem_addr];

  // ALU peripheral: 7-bit memreg, set has priority over reset.
  logic [6:0]        alu_memreg = '0;
  logic [DATA_W-1:0] alu_counter = '0;
  always @(posedge clock) begin
    if (memreg_set) alu_memreg <= res[6:0];
    else if (memreg_reset) alu_memreg <= 7'd1;
    if (counter_set) alu_counter <= alu_counter - 1'b1;
    else if (counter_reset) alu_counter <= memout;
  end
  assign counter_out = alu_counter;
  assign res = RES_W'(alu_counter) * RES_W'(alu_memreg);

  typedef struct {
    int                c0;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    int                m;
    longint            wdata;
    logic              ovf;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: N! as it survives a 7-bit memreg, with 0! = 1.
  function automatic exp_t model(input int c0, input logic [ADDR_W-1:0] s,
                                 input logic [ADDR_W-1:0] d, input int n);
    exp_t e;
    longint f = 1;
    for (int k = 2; k <= n; k++) f = f * k;
    e.c0    = c0;
    e.src   = s;
    e.dst   = d;
    e.m     = (n > 1) ? n - 1 : 0;
    e.wdata = (n == 0) ? 1 : (f % 128);
    e.ovf   = (n > MAX_N);
    return e;
  endfunction

  // Monitor: cycle-accurate comparison against the head of the scoreboard.
  exp_t mon_e;
  bit   mon_have, rd_exp, ld_exp, set_exp, wr_exp, dn_exp, bz_exp;
  always @(negedge clock) begin
    if (reset_n) begin
      mon_have = (q.size() > 0);
      if (mon_have) mon_e = q[0];
      rd_exp  = mon_have && (cyc == mon_e.c0 + 1);
      ld_exp  = mon_have && (cyc == mon_e.c0 + 2);
      set_exp = mon_have && (cyc >= mon_e.c0 + 3) && (cyc < mon_e.c0 + 3 + mon_e.m);
      wr_exp  = mon_have && (cyc == mon_e.c0 + 4 + mon_e.m);
      dn_exp  = mon_have && (cyc == mon_e.c0 + 5 + mon_e.m);
      bz_exp  = mon_have && (cyc >= mon_e.c0 + 1) && (cyc <= mon_e.c0 + 4 + mon_e.m);
      chk("busy", busy, bz_exp);
      chk("mem_rd", mem_rd, rd_exp);
      chk("memreg_reset", memreg_reset, ld_exp);
      chk("counter_reset", counter_reset, ld_exp);
      chk("memreg_set", memreg_set, set_exp);
      chk("counter_set", counter_set, set_exp);
      chk("excl", (memreg_set && memreg_reset) || (counter_set && counter_reset), 0);
      chk("mem_wr", mem_wr, wr_exp);
      chk("done", done, dn_exp);
      if (rd_exp) chk("rd_addr", mem_addr, mon_e.src);
      else if (wr_exp) begin
        chk("wr_addr", mem_addr, mon_e.dst);
        chk("wr_data", mem_wdata, mon_e.wdata);
      end else chk("addr_idle", mem_addr, 0);
      if (dn_exp) begin
        chk("overflow", overflow, mon_e.ovf);
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d ops still pending after %0d cycles", q.size(), budget);
      q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_rd"}, mem_rd, 0);
    chk({tag, "_wr"}, mem_wr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_strobes"}, {memreg_set, memreg_reset, counter_set, counter_reset}, 0);
  endtask

  // Drives start for one cycle from an idle DUT and queues the expectation.
  task automatic issue(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                       input int n, output int c0);
    mem[s] = DATA_W'(n);
    @(negedge clock); #1;
    src_addr = s;
    dst_addr = d;
    start    = 1'b1;
    c0       = cyc;
    q.push_back(model(c0, s, d, n));
    @(negedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input int n);
    int c0;
    issue(s, d, n, c0);
    wait_drain(60);
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    int cs [3];
    int ns [3];
    exp_t e;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clock);
    #1 reset_n = 1'b1;

    run_op(4'd2, 4'd9, 5);
    run_op(4'd4, 4'd1, 0);
    run_op(4'd6, 4'd7, 1);

    // start pulsed during ITER of an N=4 run must be ignored
    issue(4'd3, 4'd5, 4, c0);
    while (cyc < c0 + 5) @(negedge clock);
    #1 start = 1'b1;
    @(negedge clock); #1 start = 1'b0;
    wait_drain(60);
    repeat (3) @(negedge clock);

    // reset during the second set pulse of an N=5 run
    issue(4'd8, 4'd10, 5, c0);
    while (cyc < c0 + 4) @(negedge clock);
    #1 reset_n = 1'b0;
    q.delete();
    #1 check_all_zero("midreset");
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
    run_op(4'd11, 4'd12, 3);

    run_op(4'd13, 4'd14, 7);

    // start held high: back-to-back operations
    for (int k = 0; k < 3; k++) begin
      ns[k] = $urandom_range(0, 9);
      mem[k * 5 + 1] = DATA_W'(ns[k]);
    end
    @(negedge clock); #1;
    cs[0] = cyc;
    for (int k = 0; k < 3; k++) begin
      e = model(cs[k], ADDR_W'(k * 5 + 1), ADDR_W'(k + 12), ns[k]);
      q.push_back(e);
      if (k < 2) cs[k + 1] = cs[k] + 6 + e.m;
    end
    src_addr = ADDR_W'(1);
    dst_addr = ADDR_W'(12);
    start    = 1'b1;
    for (int k = 1; k < 3; k++) begin
      while (cyc < cs[k]) @(negedge clock);
      #1;
      src_addr = ADDR_W'(k * 5 + 1);
      dst_addr = ADDR_W'(k + 12);
    end
    while (cyc < cs[2] + 1) @(negedge clock);
    #1 start = 1'b0;
    wait_drain(60);

    // randomized operations, operands across the full 4-bit range
    for (int i = 0; i < 12; i++) begin
      run_op(ADDR_W'($urandom_range(0, 15)), ADDR_W'($urandom_range(0, 15)),
             $urandom_range(0, 15));
    end

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fact_seq_ctrl.md
Name: fact_seq_ctrl

Overview:
- Sequencing controller (initiator) for the factorial ALU datapath. The ALU holds the counter and memreg registers and drives `res = counter*memreg`.
- On a start request this block:
  - reads the operand N from data memory;
  - drives the ALU's memreg_reset / counter_reset / memreg_set / counter_set strobes until the counter reaches 1;
  - writes N! back to memory and pulses done.
- Sits between the top-level command logic, the data memory and the ALU.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 4, operand width; matches ALU memout/counter_out.
- RES_W, 16, result width; matches ALU res.
- MAX_N, 5, largest operand whose factorial fits the ALU's 7-bit memreg.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- src_addr  in  ADDR_W  operand address; captured when start is accepted.
- dst_addr  in  ADDR_W  result address; captured when start is accepted.
- busy  out  1  high in READ, LOAD, ITER, WRITE.
- done  out  1  one-cycle pulse in DONE.
- overflow  out  1  valid with done; high if captured N > MAX_N.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  read strobe; memout is valid the following cycle.
- mem_wr  out  1  write strobe.
- mem_wdata  out  RES_W  write data.
- memout  in  DATA_W  memory read data; also wired to the ALU.
- memreg_set  out  1  ALU: memreg <= res.
- memreg_reset  out  1  ALU: memreg <= 1.
- counter_set  out  1  ALU: counter <= counter-1.
- counter_reset  out  1  ALU: counter <= memout.
- counter_out  in  DATA_W  ALU counter value.
- res  in  RES_W  ALU product counter*memreg.

Behaviour:
- States: IDLE, READ, LOAD, ITER, WRITE, DONE. State is registered. Async reset forces IDLE.
- Reset values:
  - all outputs 0;
  - captured src/dst/N registers 0.
- IDLE:
  - if start=1: capture src_addr and dst_addr, go to READ;
  - otherwise stay.
- READ:
  - mem_addr=src, mem_rd=1;
  - go to LOAD.
- LOAD:
  - counter_reset=1, memreg_reset=1;
  - capture memout as N; set overflow register = (N > MAX_N);
  - go to ITER.
- ITER:
  - if counter_out > 1: memreg_set=1 and counter_set=1 in the same cycle; stay.
  - otherwise: no strobes, go to WRITE.
  - memreg_set and counter_set are combinational from state and counter_out; all other outputs decode from state only.
- WRITE:
  - mem_addr=dst, mem_wr=1;
  - mem_wdata = 1 if N==0 (the ALU gives res=0 when counter=0); otherwise res;
  - go to DONE.
- DONE:
  - done=1; overflow valid;
  - go to IDLE.
- Latency, with the accepting edge as cycle 0:
  - READ in cycle 1, LOAD in cycle 2;
  - ITER in cycles 3 .. 3+max(N-1,0);
  - WRITE in cycle 4+max(N-1,0);
  - done in cycle 5+max(N-1,0).
- Exactly max(N-1,0) set pulses occur per operation.
- Strobe exclusivity: never assert a *_set and its matching *_reset in the same cycle. The ALU gives set priority, so exclusivity is mandatory.
- Start handling:
  - start outside IDLE is ignored; it is not queued.
  - A start held high through DONE→IDLE begins a new operation on the next IDLE edge.
- Overflow:
  - N > MAX_N still runs to completion and writes the truncated res;
  - overflow is flagged only.
- Reset mid-operation:
  - immediate return to IDLE with all strobes 0;
  - no memory write; no done pulse.
  - ALU contents may be stale; the next LOAD reinitialises them.
- mem_addr is 0 outside READ and WRITE.

Test Plan:
- mem[2]=5, start with src=2, dst=9:
  - 4 cycles with memreg_set/counter_set high;
  - mem_wr in cycle 8 with mem_wdata=120 at address 9;
  - done in cycle 9; overflow=0.
- N=0 and N=1:
  - each produces zero set pulses and writes 1;
  - done in cycle 5.
- start pulsed again during ITER of an N=4 run:
  - ignored; exactly one write of 24; one done pulse;
  - busy returns low after DONE.
- reset_n low during ITER (N=5, second set pulse):
  - all outputs 0 asynchronously; no mem_wr; no done.
  - A following start with N=3 writes 6.
- N=7 (> MAX_N):
  - completes with 6 set pulses;
  - overflow=1 alongside done;
  - write occurs with the ALU-truncated res.
- start held high continuously:
  - back-to-back operations;
  - each operation begins at the IDLE cycle following DONE;
  - strobe-exclusivity assertion holds every cycle.
